stage_mem: RTL and testbench

- Memory stage of the 5-stage in-order core, directly downstream of the execute stage.
- Registers the exe2mem bundle and performs load/store accesses through a valid/ready data-memory port.
- Handles byte-lane alignment and load sign/zero extension, forwards rd to decode, and emits a mem2wb bundle to write-back.
- Stalls the pipe while a data-memory transaction is outstanding.

---
 rtl/stage_mem_if.sv | 20 ++
 rtl/stage_mem.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_stage_mem.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : gpr_forward (interface)
// Brief    : Register forwarding path from a later pipe stage to decode.
// Revision : 1.0 - initial release
// ============================================================================

interface gpr_forward;

    logic        rd_en;
    logic        rd_forward;
    logic [4:0]  rd;
    logic [63:0] rd_value;

    modport master (output rd_en, rd_forward, rd, rd_value);
    modport slave  (input  rd_en, rd_forward, rd, rd_value);

endinterface

`default_nettype wire

// File: rtl/stage_mem.sv
`default_nettype none
// ============================================================================
// Module   : stage_mem (with package stage_mem_pkg)
// Brief    : Memory stage of the 5-stage in-order core. Registers the
//            execute-stage bundle, runs load/store accesses over a
//            valid/ready data-memory port, aligns byte lanes, extends load
//            data, forwards rd to decode and hands a bundle to write-back.
// Options  : MEM_ACCESS_FAULT_EN - adds dmem_resp_err; error responses
//            raise a load/store access-fault trap and suppress the rd write.
// Revision : 1.0 - initial release
// ============================================================================

package stage_mem_pkg;

    localparam logic [3:0] EXC_LOAD_ACCESS_FAULT  = 4'd5;
    localparam logic [3:0] EXC_STORE_ACCESS_FAULT = 4'd7;

    typedef struct packed {
        logic        trap_en;
        logic        trap_is_int;
        logic [3:0]  cause;
        logic [63:0] tval;
    } trap_t;

    typedef struct packed {
        logic        rd_en;
        logic        rd_forward_exe;
        logic [4:0]  rd;
        logic        mem_en;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
    } pack_t;

    typedef struct packed {
        logic        exe_valid;
        logic        id_valid;
        logic [63:0] pc;
        pack_t       pack;
        trap_t       trap;
        logic        ctrl_trans;
        logic [63:0] ctrl_trans_addr;
        logic [63:0] mem_addr;
        logic [63:0] rs2_value;
        logic [63:0] rd_value;
    } exe2mem;

    typedef struct packed {
        logic        mem_valid;
        logic [63:0] pc;
        pack_t       pack;
        trap_t       trap;
        logic        ctrl_trans;
        logic [63:0] ctrl_trans_addr;
        logic [63:0] rd_value;
    } mem2wb;

endpackage

module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int DMEM_WIDTH = 64   // only 64 is supported
) (
    input  logic                    clock,
    input  logic                    reset,
    input  exe2mem                  mem_data_from_ex,
    input  logic                    mem_flush,
    input  logic                    mem_ready,
    output logic                    mem_stall,
    gpr_forward.master              mem_forward,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic [63:0]             dmem_req_addr,
    output logic                    dmem_req_write,
    output logic [DMEM_WIDTH-1:0]   dmem_req_wdata,
    output logic [DMEM_WIDTH/8-1:0] dmem_req_wstrb,
    input  logic                    dmem_resp_valid,
    input  logic [DMEM_WIDTH-1:0]   dmem_resp_data,
`ifdef MEM_ACCESS_FAULT_EN
    input  logic                    dmem_resp_err,
`endif
    output mem2wb                   wb_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    exe2mem                  in_q;
    logic [DMEM_WIDTH-1:0]   rdata_q;

    logic                    w_access;
    logic                    w_next_access;
    logic [2:0]              w_off;
    logic [5:0]              w_shamt;
    logic                    w_is_store;
    logic                    w_is_load;
    logic                    w_capture;
    logic [DMEM_WIDTH-1:0]   w_shifted;
    logic [63:0]             w_load_val;
    logic [63:0]             w_result;
    logic                    w_fault;
    logic                    w_rd_en;
    trap_t                   w_trap;

    // The held instruction needs a memory access (trapped ones never touch memory).
    assign w_access      = in_q.exe_valid && in_q.pack.mem_en && !in_q.trap.trap_en;
    // The instruction about to be latched needs an access; lets DONE chain straight into REQ.
    assign w_next_access = mem_data_from_ex.exe_valid && mem_data_from_ex.pack.mem_en
                           && !mem_data_from_ex.trap.trap_en;
    assign w_off         = in_q.mem_addr[2:0];
    assign w_shamt       = {w_off, 3'b000};
    assign w_is_store    = in_q.pack.mem_en && in_q.pack.mem_write;
    assign w_is_load     = in_q.pack.mem_en && !in_q.pack.mem_write && !in_q.trap.trap_en;

    // Response is taken only on the transition into DONE, so each request consumes one response.
    assign w_capture     = (state_d == S_DONE) && (state_q != S_DONE);

    // Input pipeline register: flush kills, otherwise advance when not stalled and downstream ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_q <= '0;
        end else if (mem_flush) begin
            in_q <= '0;
        end else if (!mem_stall && mem_ready) begin
            in_q <= mem_data_from_ex.exe_valid ? mem_data_from_ex : '0;
        end
    end

    // FSM state register plus the response data buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_capture) begin
                rdata_q <= dmem_resp_data;
            end
        end
    end

`ifdef MEM_ACCESS_FAULT_EN
    logic err_q;

    // Error flag travels with the captured response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (w_capture) begin
            err_q <= dmem_resp_err;
        end
    end

    assign w_fault = (state_q == S_DONE) && err_q;
`else
    assign w_fault = 1'b0;
`endif

    // Next-state logic; a flush with the handshake already done must drain the pending response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!mem_flush && w_access) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_flush) begin
                    state_d = (dmem_req_ready && !dmem_resp_valid) ? S_DRAIN : S_IDLE;
                end else if (dmem_req_ready) begin
                    state_d = dmem_resp_valid ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_resp_valid) begin
                    state_d = mem_flush ? S_IDLE : S_DONE;
                end else if (mem_flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (mem_flush) begin
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    state_d = w_next_access ? S_REQ : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dmem_resp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stall and request-side outputs; request fields come straight from the held bundle so they stay stable.
    always_comb begin
        mem_stall      = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN)
                         || ((state_q == S_IDLE) && w_access);
        dmem_req_valid = (state_q == S_REQ);
        dmem_req_write = w_is_store;
        dmem_req_wdata = '0;
        dmem_req_wstrb = '0;
        case (in_q.pack.mem_size)
            2'd0:    dmem_req_addr = in_q.mem_addr;
            2'd1:    dmem_req_addr = {in_q.mem_addr[63:1], 1'b0};
            2'd2:    dmem_req_addr = {in_q.mem_addr[63:2], 2'b00};
            default: dmem_req_addr = {in_q.mem_addr[63:3], 3'b000};
        endcase
        if (w_is_store) begin
            dmem_req_wdata = in_q.rs2_value << w_shamt;
            case (in_q.pack.mem_size)
                2'd0:    dmem_req_wstrb = 8'h01 << w_off;
                2'd1:    dmem_req_wstrb = 8'h03 << w_off;
                2'd2:    dmem_req_wstrb = 8'h0F << w_off;
                default: dmem_req_wstrb = 8'hFF;
            endcase
        end
    end

    // Load data: move the addressed bytes to bit 0, then truncate and extend.
    always_comb begin
        w_shifted  = rdata_q >> w_shamt;
        w_load_val = w_shifted;
        case (in_q.pack.mem_size)
            2'd0: w_load_val = in_q.pack.mem_unsigned ? {56'd0, w_shifted[7:0]}
                                                      : {{56{w_shifted[7]}}, w_shifted[7:0]};
            2'd1: w_load_val = in_q.pack.mem_unsigned ? {48'd0, w_shifted[15:0]}
                                                      : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_load_val = in_q.pack.mem_unsigned ? {32'd0, w_shifted[31:0]}
                                                      : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_val = w_shifted;
        endcase
    end

    // Result selection and trap override on a faulting response.
    always_comb begin
        w_result = w_is_load ? w_load_val : in_q.rd_value;
        w_rd_en  = in_q.pack.rd_en && !w_fault;
        w_trap   = in_q.trap;
        if (w_fault) begin
            w_trap.trap_en     = 1'b1;
            w_trap.trap_is_int = 1'b0;
            w_trap.cause       = in_q.pack.mem_write ? EXC_STORE_ACCESS_FAULT : EXC_LOAD_ACCESS_FAULT;
            w_trap.tval        = in_q.mem_addr;
        end
    end

    // Write-back bundle: pass-through fields plus result, valid only on a real handoff.
    always_comb begin
        wb_data                 = '0;
        wb_data.mem_valid       = !mem_stall && mem_ready && in_q.id_valid;
        wb_data.pc              = in_q.pc;
        wb_data.pack            = in_q.pack;
        wb_data.pack.rd_en      = w_rd_en;
        wb_data.trap            = w_trap;
        wb_data.ctrl_trans      = in_q.ctrl_trans;
        wb_data.ctrl_trans_addr = in_q.ctrl_trans_addr;
        wb_data.rd_value        = w_result;
    end

    assign mem_forward.rd_en      = w_rd_en;
    assign mem_forward.rd_forward = in_q.pack.rd_forward_exe || !in_q.pack.mem_en
                                    || (state_q == S_DONE);
    assign mem_forward.rd         = in_q.pack.rd;
    assign mem_forward.rd_value   = w_result;

endmodule

`default_nettype wire

// File: tb/tb_stage_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_mem
// Brief    : Directed self-checking bench for the memory stage.
// Revision : 1.0 - initial release
// ============================================================================

module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    exe2mem      ex;
    logic        mem_flush;
    logic        mem_ready;
    logic        mem_stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_req_addr;
    logic        dmem_req_write;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_data;
    mem2wb       wb_data;
`ifdef MEM_ACCESS_FAULT_EN
    logic        dmem_resp_err;
    logic        inject_err;
`endif

    gpr_forward fwd();

    stage_mem #(.DMEM_WIDTH(64)) dut (
        .clock            (clock),
        .reset            (reset),
        .mem_data_from_ex (ex),
        .mem_flush        (mem_flush),
        .mem_ready        (mem_ready),
        .mem_stall        (mem_stall),
        .mem_forward      (fwd),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_req_addr    (dmem_req_addr),
        .dmem_req_write   (dmem_req_write),
        .dmem_req_wdata   (dmem_req_wdata),
        .dmem_req_wstrb   (dmem_req_wstrb),
        .dmem_resp_valid  (dmem_resp_valid),
        .dmem_resp_data   (dmem_resp_data),
`ifdef MEM_ACCESS_FAULT_EN
        .dmem_resp_err    (dmem_resp_err),
`endif
        .wb_data          (wb_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic exe2mem mk(input logic men, input logic wr, input logic [1:0] sz,
                                  input logic uns, input logic [63:0] addr,
                                  input logic [63:0] rs2, input logic [63:0] rdv);
        exe2mem b;
        b                     = '0;
        b.exe_valid           = 1'b1;
        b.id_valid            = 1'b1;
        b.pc                  = 64'h8000_0000 + addr;
        b.pack.rd_en          = !wr;
        b.pack.rd             = 5'd7;
        b.pack.mem_en         = men;
        b.pack.mem_write      = wr;
        b.pack.mem_size       = sz;
        b.pack.mem_unsigned   = uns;
        b.mem_addr            = addr;
        b.rs2_value           = rs2;
        b.rd_value            = rdv;
        return b;
    endfunction

    // Latch an access, hold req_ready low for req_delay cycles, ack, respond; ends in DONE.
    task automatic access(input exe2mem b, input int req_delay, input logic [63:0] exp_addr,
                          input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                          input logic [63:0] rdata);
        int n;
        ex = b;
        step();
        ex = '0;
        check("stall_after_latch", mem_stall, 1);
        n = 0;
        while (!dmem_req_valid && n < 8) begin
            step();
            n++;
        end
        check("req_valid", dmem_req_valid, 1);
        check("req_addr", dmem_req_addr, exp_addr);
        check("req_strb", dmem_req_wstrb, exp_strb);
        check("req_write", dmem_req_write, b.pack.mem_write);
        if (b.pack.mem_write) check("req_wdata", dmem_req_wdata, exp_wdata);
        for (int i = 0; i < req_delay; i++) begin
            step();
            check("req_hold_valid", dmem_req_valid, 1);
            check("req_hold_addr", dmem_req_addr, exp_addr);
            check("req_hold_strb", dmem_req_wstrb, exp_strb);
            check("req_hold_wdata", dmem_req_wdata, exp_wdata);
            check("req_hold_no_wb", wb_data.mem_valid, 0);
        end
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        check("wait_stall", mem_stall, 1);
        check("wait_req_low", dmem_req_valid, 0);
        check("wait_no_wb", wb_data.mem_valid, 0);
        check("wait_fwd_pending", fwd.rd_forward, 0);
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = rdata;
`ifdef MEM_ACCESS_FAULT_EN
        dmem_resp_err   = inject_err;
`endif
        step();
        dmem_resp_valid = 1'b0;
`ifdef MEM_ACCESS_FAULT_EN
        dmem_resp_err   = 1'b0;
`endif
        check("done_stall", mem_stall, 0);
        check("done_wb_valid", wb_data.mem_valid, 1);
        check("done_fwd_ready", fwd.rd_forward, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exe2mem ld;
        reset           = 1'b0;
        ex              = '0;
        mem_flush       = 1'b0;
        mem_ready       = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_data  = '0;
`ifdef MEM_ACCESS_FAULT_EN
        dmem_resp_err   = 1'b0;
        inject_err      = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_valid", dmem_req_valid, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_wb_valid", wb_data.mem_valid, 0);
        check("rst_wb_rd_value", wb_data.rd_value, 0);
        check("rst_wb_pc", wb_data.pc, 0);
        check("rst_fwd_rd_en", fwd.rd_en, 0);
        check("rst_wstrb", dmem_req_wstrb, 0);
        reset = 1'b1;
        step();

        // LB, signed, byte 3
        access(mk(1, 0, 2'd0, 0, 64'h1003, 64'h0, 64'h55), 0, 64'h1003, 8'h00, 64'h0,
               64'h0000_0000_8000_0000);
        check("lb_rd_value", wb_data.rd_value, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_fwd_value", fwd.rd_value, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_fwd_rd_en", fwd.rd_en, 1);
        check("lb_wb_rd_en", wb_data.pack.rd_en, 1);
        step();
        check("lb_idle_after", mem_stall, 0);

        // LBU, same byte
        access(mk(1, 0, 2'd0, 1, 64'h1003, 64'h0, 64'h55), 0, 64'h1003, 8'h00, 64'h0,
               64'h0000_0000_8000_0000);
        check("lbu_rd_value", wb_data.rd_value, 64'h80);
        step();

        // LW signed, upper word
        access(mk(1, 0, 2'd2, 0, 64'h4004, 64'h0, 64'h0), 1, 64'h4004, 8'h00, 64'h0,
               64'h8765_4321_0000_0000);
        check("lw_rd_value", wb_data.rd_value, 64'hFFFF_FFFF_8765_4321);
        step();

        // LHU, top halfword
        access(mk(1, 0, 2'd1, 1, 64'h5006, 64'h0, 64'h0), 0, 64'h5006, 8'h00, 64'h0,
               64'h9ABC_0000_0000_0000);
        check("lhu_rd_value", wb_data.rd_value, 64'h9ABC);
        step();

        // SH at offset 6 with delayed ready
        access(mk(1, 1, 2'd1, 0, 64'h2006, 64'hABCD, 64'h77), 3, 64'h2006, 8'hC0,
               64'hABCD_0000_0000_0000, 64'h0);
        check("sh_rd_value_pass", wb_data.rd_value, 64'h77);
        check("sh_rd_en", wb_data.pack.rd_en, 0);
        step();

        // Non-memory instruction passes through with no stall
        ex = mk(0, 0, 2'd0, 0, 64'h0, 64'h0, 64'h1234);
        step();
        ex = '0;
        check("alu_stall", mem_stall, 0);
        check("alu_wb_valid", wb_data.mem_valid, 1);
        check("alu_rd_value", wb_data.rd_value, 64'h1234);
        check("alu_no_req", dmem_req_valid, 0);
        check("alu_fwd", fwd.rd_forward, 1);
        step();

        // Back-to-back LD with ready held high and 1-cycle response latency
        dmem_req_ready = 1'b1;
        ex = mk(1, 0, 2'd3, 0, 64'h6000, 64'h0, 64'h0);
        step();
        ex = mk(1, 0, 2'd3, 0, 64'h6008, 64'h0, 64'h0);
        step();
        check("b2b_req1_valid", dmem_req_valid, 1);
        check("b2b_req1_addr", dmem_req_addr, 64'h6000);
        step();
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'h1111_2222_3333_4444;
        step();
        dmem_resp_valid = 1'b0;
        check("b2b_done1_valid", wb_data.mem_valid, 1);
        check("b2b_done1_value", wb_data.rd_value, 64'h1111_2222_3333_4444);
        step();
        ex = '0;
        check("b2b_req2_valid", dmem_req_valid, 1);
        check("b2b_req2_addr", dmem_req_addr, 64'h6008);
        check("b2b_req2_stall", mem_stall, 1);
        step();
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'h5555_6666_7777_8888;
        step();
        dmem_resp_valid = 1'b0;
        dmem_req_ready  = 1'b0;
        check("b2b_done2_valid", wb_data.mem_valid, 1);
        check("b2b_done2_value", wb_data.rd_value, 64'h5555_6666_7777_8888);
        step();

        // Flush while waiting for the response
        ex = mk(1, 0, 2'd3, 0, 64'h7000, 64'h0, 64'h0);
        step();
        ex = '0;
        step();
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        mem_flush = 1'b1;
        step();
        mem_flush = 1'b0;
        check("drain_stall", mem_stall, 1);
        check("drain_no_req", dmem_req_valid, 0);
        check("drain_no_wb", wb_data.mem_valid, 0);
        ex = mk(0, 0, 2'd0, 0, 64'h0, 64'h0, 64'h4242);
        step();
        check("drain_hold", mem_stall, 1);
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        dmem_resp_valid = 1'b0;
        check("drain_exit_stall", mem_stall, 0);
        step();
        ex = '0;
        check("post_drain_valid", wb_data.mem_valid, 1);
        check("post_drain_value", wb_data.rd_value, 64'h4242);
        step();
        ex = mk(1, 0, 2'd3, 0, 64'h7008, 64'h0, 64'h0);
        step();
        ex = '0;
        step();
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        step();
        check("no_extra_resp", mem_stall, 1);
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'h0123_4567_89AB_CDEF;
        step();
        dmem_resp_valid = 1'b0;
        check("post_drain_ld_value", wb_data.rd_value, 64'h0123_4567_89AB_CDEF);
        step();

        // Asynchronous reset while a request is pending
        ex = mk(1, 0, 2'd3, 0, 64'h8000, 64'h0, 64'h99);
        step();
        ex = '0;
        step();
        check("pre_rst_req", dmem_req_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_req_valid", dmem_req_valid, 0);
        check("arst_stall", mem_stall, 0);
        check("arst_wb_valid", wb_data.mem_valid, 0);
        check("arst_wb_rd_value", wb_data.rd_value, 0);
        check("arst_wb_pc", wb_data.pc, 0);
        step();
        reset = 1'b1;
        step();
        check("post_rst_idle", dmem_req_valid, 0);

`ifdef MEM_ACCESS_FAULT_EN
        // Error response on a load raises an access fault
        inject_err = 1'b1;
        access(mk(1, 0, 2'd2, 0, 64'h3000, 64'h0, 64'h0), 0, 64'h3000, 8'h00, 64'h0,
               64'h0);
        inject_err = 1'b0;
        check("fault_trap_en", wb_data.trap.trap_en, 1);
        check("fault_is_int", wb_data.trap.trap_is_int, 0);
        check("fault_cause", wb_data.trap.cause, EXC_LOAD_ACCESS_FAULT);
        check("fault_tval", wb_data.trap.tval, 64'h3000);
        check("fault_wb_rd_en", wb_data.pack.rd_en, 0);
        check("fault_fwd_rd_en", fwd.rd_en, 0);
        step();
`endif

        ld = mk(1, 0, 2'd3, 0, 64'h9000, 64'h0, 64'h0);
        access(ld, 0, 64'h9000, 8'h00, 64'h0, 64'hCAFE_F00D_0000_0001);
        check("final_ld_value", wb_data.rd_value, 64'hCAFE_F00D_0000_0001);
        check("final_trap_clear", wb_data.trap.trap_en, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
